fifo_fwft_reader: RTL and testbench

//  Read-side stage downstream of fifo_controller plus its synchronous-read RAM.

---
 rtl/fifo_fwft_reader_pkg.sv | 17 +
 rtl/fifo_fwft_reader_skid_buffer.sv | 52 +++++
 rtl/fifo_fwft_reader.sv | 63 ++++++
 tb/tb_fifo_fwft_reader.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_fwft_reader_pkg.sv
// Shared definitions for the FWFT read stage: default widths, the buffer
// level type and the occupancy helper used by the take decision.
package fifo_fwft_reader_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;
    localparam int LEVEL_W            = 2;

    typedef logic [LEVEL_W-1:0] level_t;

    // Words that will be held once the current edge retires: buffered words
    // plus the read still returning from RAM, minus the word leaving now.
    // A pop always implies count >= 1, so this never wraps below zero.
    function automatic level_t pending_words(level_t count, logic inflight, logic pop);
        return count + level_t'(inflight) - level_t'(pop);
    endfunction

endpackage

// File: rtl/fifo_fwft_reader_skid_buffer.sv
// Two-entry in-order holding buffer. slot0 is always the head word; a push
// lands in the first free slot, a pop shifts slot1 forward.
module fifo_fwft_reader_skid_buffer
    import fifo_fwft_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output level_t                count,
    output logic [DATA_WIDTH-1:0] head
);

    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;

    // Occupancy and slot contents; reset wins over clear, clear drops everything.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
            slot0 <= '0;
            slot1 <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (pop && !push) begin
            slot0 <= slot1;
            count <= count - level_t'(1);
        end else if (push && !pop) begin
            if (count == level_t'(0)) begin
                slot0 <= push_data;
            end else begin
                slot1 <= push_data;
            end
            count <= count + level_t'(1);
        end else if (push && pop) begin
            // Occupancy unchanged: the new word goes behind whatever survives.
            if (count == level_t'(1)) begin
                slot0 <= push_data;
            end else begin
                slot0 <= slot1;
                slot1 <= push_data;
            end
        end
    end

    assign head = slot0;

endmodule

// File: rtl/fifo_fwft_reader.sv
// First-word-fall-through read stage behind the FIFO controller and its
// synchronous-read RAM. Issues takes only when the returning word is sure to
// find room in the two-entry buffer, so one-cycle RAM latency still sustains
// one word per clock.
module fifo_fwft_reader
    import fifo_fwft_reader_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  in_clock,
    input  logic                  in_reset_n,
    input  logic                  in_flush,
    input  logic                  in_fifo_empty,
    output logic                  out_fifo_take,
    input  logic [DATA_WIDTH-1:0] in_ram_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  in_ready,
    output logic [LEVEL_W-1:0]    out_level
);

    level_t count;
    logic   inflight;
    logic   pop;
    logic   capture;
    level_t pending;

    assign out_valid = (count != level_t'(0));
    assign pop       = out_valid && in_ready;
    assign pending   = pending_words(count, inflight, pop);

    // A word returning during a flush belongs to the discarded stream.
    assign capture   = inflight && !in_flush;

    // Gating on reset keeps the controller's pointer still while both reset.
    assign out_fifo_take = in_reset_n && !in_fifo_empty && !in_flush &&
                           (pending < level_t'(2));

    // Tracks the RAM read issued at the previous edge.
    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= out_fifo_take;
        end
    end

    fifo_fwft_reader_skid_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buffer (
        .clock     (in_clock),
        .reset_n   (in_reset_n),
        .clear     (in_flush),
        .push      (capture),
        .push_data (in_ram_data),
        .pop       (pop),
        .count     (count),
        .head      (out_data)
    );

    assign out_level = count;

endmodule

// File: tb/tb_fifo_fwft_reader.sv
// Self-checking bench for fifo_fwft_reader. The FIFO controller plus RAM is
// modelled as a word queue whose front is read out one cycle after a take;
// the expected reader state is a queue of buffered words plus an in-flight flag.
module tb_fifo_fwft_reader;

    logic       in_clock;
    logic       in_reset_n;
    logic       in_flush;
    logic       in_fifo_empty;
    logic       out_fifo_take;
    logic [7:0] in_ram_data;
    logic       out_valid;
    logic [7:0] out_data;
    logic       in_ready;
    logic [1:0] out_level;

    fifo_fwft_reader #(.DATA_WIDTH(8)) dut (
        .in_clock      (in_clock),
        .in_reset_n    (in_reset_n),
        .in_flush      (in_flush),
        .in_fifo_empty (in_fifo_empty),
        .out_fifo_take (out_fifo_take),
        .in_ram_data   (in_ram_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .in_ready      (in_ready),
        .out_level     (out_level)
    );

    initial in_clock = 1'b0;
    always #5 in_clock = ~in_clock;

    int checks = 0;
    int errors = 0;

    logic [7:0] env_q[$];     // words stored in the upstream FIFO
    logic [7:0] ram_reg;      // what the RAM presents this cycle
    logic [7:0] mq[$];        // expected buffered words, head first
    bit         m_inflight;
    logic [7:0] dut_popped[$];
    int         n_takes;
    int         step_idx;
    int         first_v;
    int         last_v;
    int         n_valid;

    task automatic clear_stats();
        n_takes = 0; step_idx = 0; first_v = -1; last_v = -1; n_valid = 0;
        dut_popped.delete();
    endtask

    // One clock: drive inputs after the falling edge, check just before the
    // rising edge, then advance the environment and expected state.
    task automatic step(input logic rst_n, input logic fl, input logic rdy);
        bit pop_e, take_e;
        int load;
        in_reset_n    = rst_n;
        in_flush      = fl;
        in_ready      = rdy;
        in_fifo_empty = (env_q.size() == 0);
        in_ram_data   = ram_reg;
        pop_e  = (mq.size() != 0) && rdy;
        load   = mq.size() + (m_inflight ? 1 : 0) - (pop_e ? 1 : 0);
        take_e = rst_n && (env_q.size() != 0) && !fl && (load < 2);
        #1;
        checks++;
        if (out_fifo_take !== take_e) begin
            errors++; $display("FAIL take: got %b expected %b at t=%0t", out_fifo_take, take_e, $time);
        end
        checks++;
        if (out_valid !== (mq.size() != 0)) begin
            errors++; $display("FAIL valid: got %b expected %b at t=%0t", out_valid, mq.size() != 0, $time);
        end
        checks++;
        if (out_level !== 2'(mq.size())) begin
            errors++; $display("FAIL level: got %0d expected %0d at t=%0t", out_level, mq.size(), $time);
        end
        if (mq.size() != 0) begin
            checks++;
            if (out_data !== mq[0]) begin
                errors++; $display("FAIL data: got %02h expected %02h at t=%0t", out_data, mq[0], $time);
            end
        end
        if (out_valid === 1'b1) begin
            n_valid++;
            if (first_v < 0) first_v = step_idx;
            last_v = step_idx;
            if (rdy) dut_popped.push_back(out_data);
        end
        if (out_fifo_take === 1'b1) n_takes++;
        @(posedge in_clock);
        if (!rst_n) begin
            mq.delete(); m_inflight = 0; env_q.delete(); ram_reg = 8'($urandom);
        end else if (fl) begin
            mq.delete(); m_inflight = 0; ram_reg = 8'($urandom);
        end else begin
            if (pop_e) void'(mq.pop_front());
            if (m_inflight) mq.push_back(ram_reg);
            m_inflight = take_e;
            if (take_e) ram_reg = env_q.pop_front();
            else        ram_reg = 8'($urandom);
        end
        step_idx++;
        @(negedge in_clock);
    endtask

    task automatic check_popped(input string name, input logic [7:0] first, input int n);
        checks++;
        if (dut_popped.size() != n) begin
            errors++; $display("FAIL %s_count: got %0d expected %0d", name, dut_popped.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (dut_popped[i] !== 8'(first + i)) begin
                    errors++; $display("FAIL %s_order[%0d]: got %02h expected %02h", name, i, dut_popped[i], 8'(first + i));
                end
            end
        end
    endtask

    task automatic test_reset();
        clear_stats();
        repeat (2) step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        checks++;
        if (out_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %02h expected 00", out_data);
        end
        checks++;
        if (n_takes != 0 || n_valid != 0) begin
            errors++; $display("FAIL reset_idle: takes %0d valid %0d expected 0 0", n_takes, n_valid);
        end
    endtask

    task automatic test_single();
        clear_stats();
        env_q.push_back(8'hA5);
        repeat (5) step(1'b1, 1'b0, 1'b1);
        checks++;
        if (n_takes != 1) begin
            errors++; $display("FAIL single_takes: got %0d expected 1", n_takes);
        end
        checks++;
        if (first_v != 2) begin
            errors++; $display("FAIL single_latency: got %0d expected 2", first_v);
        end
        check_popped("single", 8'hA5, 1);
        checks++;
        if (out_level !== 2'd0) begin
            errors++; $display("FAIL single_level: got %0d expected 0", out_level);
        end
    endtask

    task automatic test_stream();
        clear_stats();
        for (int i = 0; i < 16; i++) env_q.push_back(8'(i));
        repeat (22) step(1'b1, 1'b0, 1'b1);
        checks++;
        if (n_takes != 16) begin
            errors++; $display("FAIL stream_takes: got %0d expected 16", n_takes);
        end
        checks++;
        if (n_valid != 16 || last_v - first_v != 15) begin
            errors++; $display("FAIL stream_gaps: got %0d valid over %0d cycles expected 16 over 16", n_valid, last_v - first_v + 1);
        end
        check_popped("stream", 8'h00, 16);
    endtask

    task automatic test_backpressure();
        clear_stats();
        for (int i = 0; i < 16; i++) env_q.push_back(8'(i));
        repeat (6) step(1'b1, 1'b0, 1'b0);
        checks++;
        if (n_takes != 2) begin
            errors++; $display("FAIL bp_takes: got %0d expected 2", n_takes);
        end
        checks++;
        if (out_level !== 2'd2 || out_data !== 8'h00) begin
            errors++; $display("FAIL bp_hold: got level %0d data %02h expected 2 00", out_level, out_data);
        end
        repeat (20) step(1'b1, 1'b0, 1'b1);
        checks++;
        if (n_takes != 16) begin
            errors++; $display("FAIL bp_total_takes: got %0d expected 16", n_takes);
        end
        check_popped("bp", 8'h00, 16);
    endtask

    task automatic test_flush();
        clear_stats();
        env_q.push_back(8'h40);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        env_q.push_back(8'h41);
        env_q.push_back(8'h42);
        step(1'b1, 1'b0, 1'b0);     // takes 0x41 with level 1
        step(1'b1, 1'b1, 1'b0);     // 0x41 returns during the flush
        checks++;
        if (out_level !== 2'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got level %0d valid %b expected 0 0", out_level, out_valid);
        end
        clear_stats();
        repeat (5) step(1'b1, 1'b0, 1'b1);
        check_popped("flush_resume", 8'h42, 1);
    endtask

    task automatic test_reset_midflight();
        clear_stats();
        for (int i = 0; i < 4; i++) env_q.push_back(8'(8'h50 + i));
        repeat (2) step(1'b1, 1'b0, 1'b0);   // level 1 with a read in flight
        step(1'b0, 1'b0, 1'b1);
        checks++;
        if (out_valid !== 1'b0 || out_level !== 2'd0 || out_data !== 8'h00) begin
            errors++; $display("FAIL midreset: got valid %b level %0d data %02h expected 0 0 00", out_valid, out_level, out_data);
        end
        clear_stats();
        env_q.push_back(8'h77);
        repeat (5) step(1'b1, 1'b0, 1'b1);
        check_popped("midreset_after", 8'h77, 1);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0 && env_q.size() < 16) env_q.push_back(8'($urandom));
            step(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        in_reset_n = 1'b0; in_flush = 1'b0; in_ready = 1'b0;
        in_fifo_empty = 1'b1; in_ram_data = 8'h00;
        ram_reg = 8'h00; m_inflight = 0;
        repeat (2) @(posedge in_clock);
        @(negedge in_clock);
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
